// File: rtl/uart_link_pkg.sv
// Shared encodings and constants for the uart_link block.
// UART_LINK_PARITY_EN adds the parity states to both FSMs.
package uart_link_pkg;

  localparam int unsigned FrameBits   = 8;
  localparam int unsigned BaudDefault = 104;

`ifdef UART_LINK_PARITY_EN
  typedef enum logic [4:0] {
    RxIdle   = 5'b00001,
    RxStart  = 5'b00010,
    RxData   = 5'b00100,
    RxParity = 5'b01000,
    RxStop   = 5'b10000
  } rx_state_e;

  typedef enum logic [4:0] {
    TxIdle   = 5'b00001,
    TxStart  = 5'b00010,
    TxData   = 5'b00100,
    TxParity = 5'b01000,
    TxStop   = 5'b10000
  } tx_state_e;
`else
  typedef enum logic [3:0] {
    RxIdle  = 4'b0001,
    RxStart = 4'b0010,
    RxData  = 4'b0100,
    RxStop  = 4'b1000
  } rx_state_e;

  typedef enum logic [3:0] {
    TxIdle  = 4'b0001,
    TxStart = 4'b0010,
    TxData  = 4'b0100,
    TxStop  = 4'b1000
  } tx_state_e;
`endif

endpackage

// File: rtl/byte_fifo.sv
// Circular FIFO with extra-MSB pointers; a push into a full FIFO only lands
// when a pop happens in the same cycle.
module byte_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [AddrW:0]   wr_ptr_q, rd_ptr_q;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_ptr_q[AddrW-1:0]];

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q[AddrW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/uart_link.sv
// Byte UART link: synchronised RX into a byte_fifo, TX serialiser, sticky errors.
// Define UART_LINK_PARITY_EN for even-parity frames in both directions.
module uart_link
  import uart_link_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = BaudDefault,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic [7:0] read_data_o,
  output logic       read_valid_o,
  input  logic       read_ready_i,
  input  logic [7:0] write_data_i,
  input  logic       write_valid_i,
  output logic       write_ready_o,
  output logic       error_framing_o,
  output logic       error_overflow_o,
  output logic       error_parity_o
);

  localparam int unsigned       TimerW  = $clog2(CLKS_PER_BIT);
  localparam logic [TimerW-1:0] BitEnd  = TimerW'(CLKS_PER_BIT - 1);
  localparam logic [TimerW-1:0] HalfEnd = TimerW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]        LastBit = 3'(FrameBits - 1);

  logic              rx_meta_q, rx_sync_q;
  rx_state_e         rx_state_q, rx_state_d;
  logic [TimerW-1:0] rx_timer_q, rx_timer_d;
  logic [2:0]        rx_bit_q, rx_bit_d;
  logic [7:0]        rx_shift_q, rx_shift_d;
  logic              rx_push, framing_set, overflow_set;
  logic              framing_err_q, overflow_err_q;

  tx_state_e         tx_state_q, tx_state_d;
  logic [TimerW-1:0] tx_timer_q, tx_timer_d;
  logic [2:0]        tx_bit_q, tx_bit_d;
  logic [7:0]        tx_shift_q, tx_shift_d;

  logic [7:0] fifo_head;
  logic       fifo_full, fifo_empty, fifo_pop;

`ifdef UART_LINK_PARITY_EN
  logic rx_par_bad_q, rx_par_bad_d, parity_set, parity_err_q;
  logic tx_par_q, tx_par_d;
`endif

  // RX next state
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_timer_d  = rx_timer_q + TimerW'(1);
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_push     = 1'b0;
    framing_set = 1'b0;
`ifdef UART_LINK_PARITY_EN
    rx_par_bad_d = rx_par_bad_q;
    parity_set   = 1'b0;
`endif
    unique case (rx_state_q)
      RxIdle: begin
        rx_timer_d = '0;
        if (!rx_sync_q) rx_state_d = RxStart;
      end
      RxStart: begin
        if (rx_timer_q == HalfEnd) begin
          rx_timer_d = '0;
          rx_bit_d   = '0;
`ifdef UART_LINK_PARITY_EN
          rx_par_bad_d = 1'b0;
`endif
          // A start bit that is high again at mid-bit was only a glitch.
          rx_state_d = rx_sync_q ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (rx_timer_q == BitEnd) begin
          rx_timer_d = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == LastBit) begin
`ifdef UART_LINK_PARITY_EN
            rx_state_d = RxParity;
`else
            rx_state_d = RxStop;
`endif
          end
        end
      end
`ifdef UART_LINK_PARITY_EN
      RxParity: begin
        if (rx_timer_q == BitEnd) begin
          rx_timer_d   = '0;
          rx_par_bad_d = (rx_sync_q != ^rx_shift_q);
          parity_set   = rx_par_bad_d;
          rx_state_d   = RxStop;
        end
      end
`endif
      RxStop: begin
        if (rx_timer_q == BitEnd) begin
          rx_timer_d = '0;
          rx_state_d = RxIdle;
          if (rx_sync_q) begin
`ifdef UART_LINK_PARITY_EN
            rx_push = !rx_par_bad_q;
`else
            rx_push = 1'b1;
`endif
          end else begin
            framing_set = 1'b1;
          end
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // TX next state and line drive
  always_comb begin
    tx_state_d = tx_state_q;
    tx_timer_d = tx_timer_q + TimerW'(1);
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    uart_tx    = 1'b1;
`ifdef UART_LINK_PARITY_EN
    tx_par_d = tx_par_q;
`endif
    unique case (tx_state_q)
      TxIdle: begin
        tx_timer_d = '0;
        if (write_valid_i) begin
          tx_shift_d = write_data_i;
          tx_state_d = TxStart;
`ifdef UART_LINK_PARITY_EN
          tx_par_d = ^write_data_i;
`endif
        end
      end
      TxStart: begin
        uart_tx = 1'b0;
        if (tx_timer_q == BitEnd) begin
          tx_timer_d = '0;
          tx_bit_d   = '0;
          tx_state_d = TxData;
        end
      end
      TxData: begin
        uart_tx = tx_shift_q[0];
        if (tx_timer_q == BitEnd) begin
          tx_timer_d = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == LastBit) begin
`ifdef UART_LINK_PARITY_EN
            tx_state_d = TxParity;
`else
            tx_state_d = TxStop;
`endif
          end
        end
      end
`ifdef UART_LINK_PARITY_EN
      TxParity: begin
        uart_tx = tx_par_q;
        if (tx_timer_q == BitEnd) begin
          tx_timer_d = '0;
          tx_state_d = TxStop;
        end
      end
`endif
      TxStop: begin
        if (tx_timer_q == BitEnd) begin
          tx_timer_d = '0;
          tx_state_d = TxIdle;
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= RxIdle;
      rx_timer_q <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      tx_state_q <= TxIdle;
      tx_timer_q <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
    end else begin
      rx_meta_q  <= uart_rx;
      rx_sync_q  <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_timer_q <= rx_timer_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      tx_state_q <= tx_state_d;
      tx_timer_q <= tx_timer_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  assign fifo_pop     = read_ready_i && !fifo_empty;
  assign overflow_set = rx_push && fifo_full && !fifo_pop;

  always_ff @(posedge clock) begin
    if (!reset) begin
      framing_err_q  <= 1'b0;
      overflow_err_q <= 1'b0;
    end else begin
      if (framing_set)  framing_err_q  <= 1'b1;
      if (overflow_set) overflow_err_q <= 1'b1;
    end
  end

`ifdef UART_LINK_PARITY_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_par_bad_q <= 1'b0;
      parity_err_q <= 1'b0;
      tx_par_q     <= 1'b0;
    end else begin
      rx_par_bad_q <= rx_par_bad_d;
      tx_par_q     <= tx_par_d;
      if (parity_set) parity_err_q <= 1'b1;
    end
  end
  assign error_parity_o = parity_err_q;
`else
  assign error_parity_o = 1'b0;
`endif

  byte_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (8)
  ) u_rx_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (rx_push),
    .push_data_i (rx_shift_q),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign read_valid_o     = !fifo_empty;
  assign read_data_o      = fifo_empty ? 8'h00 : fifo_head;
  assign write_ready_o    = (tx_state_q == TxIdle);
  assign error_framing_o  = framing_err_q;
  assign error_overflow_o = overflow_err_q;

endmodule

// File: doc/uart_link.md
# uart_link

Byte-level UART link between the host serial line and the low-speed command core. Deserialises host bytes into a small receive FIFO that feeds the core's command input (valid/ready). Serialises the core's response bytes back onto the line. Reports framing and overflow errors as sticky flags.

## Interface

Parameters:
- CLKS_PER_BIT, 104: system clocks per UART bit (12 MHz / 115200); must be ≥ 4.
- FIFO_DEPTH, 4: receive FIFO entries; power of two, ≥ 2.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low.
- uart_rx  in  1  serial input from host, asynchronous, idle high.
- uart_tx  out  1  serial output to host, idle high.
- read_data_o  out  8  head byte of the RX FIFO, to the core.
- read_valid_o  out  1  RX FIFO non-empty.
- read_ready_i  in  1  core pops the head byte.
- write_data_i  in  8  response byte from the core.
- write_valid_i  in  1  core offers a byte.
- write_ready_o  out  1  TX serialiser idle; byte accepted this cycle.
- error_framing_o  out  1  sticky; stop bit sampled low.
- error_overflow_o  out  1  sticky; byte completed while the FIFO was full.
- error_parity_o  out  1  sticky; parity mismatch (see Configuration).

## Operation

- **Transfer rule:** a byte moves on any cycle where valid and ready are both high, on either side.
- **RX synchroniser:** uart_rx passes through a 2-flop synchroniser. All RX logic uses the synchronised signal.
- **RX FSM states:**
  - RX_IDLE: a low on the synchronised line moves to RX_START with the bit timer cleared.
  - RX_START: after CLKS_PER_BIT/2 (integer division), re-sample. Low → RX_DATA. High → RX_IDLE; treated as a glitch, no error.
  - RX_DATA: sample every CLKS_PER_BIT, LSB first, 8 bits. Then RX_PARITY if enabled, else RX_STOP.
  - RX_STOP: sample after CLKS_PER_BIT.
    - High: push the byte.
    - Low: set error_framing_o and discard the byte.
    - Either way, return to RX_IDLE. A low line re-arms start detection next cycle.
- **RX FIFO:** circular, read/write pointers of log2(FIFO_DEPTH)+1 bits. Full means the MSBs differ and the LSBs are equal.
  - Push on a full FIFO with no simultaneous pop: drop the byte, set error_overflow_o.
  - Push and pop in the same cycle on a full FIFO: both succeed, no error.
  - Pop on an empty FIFO: ignored.
- **TX FSM states:** TX_IDLE → TX_START → TX_DATA (8 bits, LSB first) → [TX_PARITY] → TX_STOP → TX_IDLE. Each bit is held for exactly CLKS_PER_BIT cycles.
  - The byte is latched on acceptance, so write_data_i may change afterwards.
  - write_ready_o = (tx_state == TX_IDLE).
- **Error flags:** clear only on reset.
- **Reset values:** uart_tx=1, read_valid_o=0, read_data_o=0, write_ready_o=1, all error flags 0, both FSMs idle, FIFO empty.
- **Reset mid-operation:** frames in progress in either direction are abandoned. uart_tx returns high on the next cycle.

## Timing

- **RX latency:** read_valid_o rises 1 cycle after the stop-bit sample cycle.
- **Stop-bit sample position:** about (9.5 × CLKS_PER_BIT + 2) cycles after the line falls, with parity disabled. The +2 is the synchroniser.
- **Read path:** read_data_o is combinational from the FIFO head. A pop at edge N presents the next entry after edge N.
- **TX start:** acceptance at edge N drives uart_tx low from cycle N+1.
- **TX frame length:** 10 × CLKS_PER_BIT cycles (11 with parity).
- **Next acceptance:** write_ready_o re-asserts in the cycle after the stop bit completes.
- **Full duplex:** RX and TX run concurrently and independently.

## Configuration

- **UART_LINK_PARITY_EN defined:** even parity on both directions.
  - RX samples a parity bit after bit 7. On mismatch: set error_parity_o and discard the byte; the stop bit is still checked.
  - TX sends the XOR of the data bits after bit 7.
- **UART_LINK_PARITY_EN undefined:** 8N1 frames. error_parity_o is tied to 0 and no parity states exist.

## Structure

- **Shared package `uart_link_pkg`:** RX and TX state encodings (one-hot), the frame bit count (8), and the baud default constant.
- **Sub-module `byte_fifo`:** the parameterised FIFO with push/pop/full/empty. It is reusable for a later TX-side buffer.
- **In `uart_link`:** the RX and TX FSMs stay in this module.

## Test plan

All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=4, parity off unless stated.

- **Single RX byte:** drive 0x41 on uart_rx → read_valid_o rises, read_data_o=0x41. Pop with read_ready_i=1 → read_valid_o falls.
- **Overflow:** 5 back-to-back RX bytes 0x01–0x05 with read_ready_i=0 → FIFO holds 0x01–0x04, error_overflow_o=1. Popping yields 0x01, 0x02, 0x03, 0x04.
- **Framing error and glitch:**
  - Frame 0x55 with stop bit low → error_framing_o=1, no byte pushed.
  - 1-cycle low glitch → no byte, no error.
- **TX:** offer 0xC3 → write_ready_o low for 40 cycles. uart_tx shows 0, then 1,1,0,0,0,0,1,1, then 1, each bit 4 cycles wide.
- **Full duplex and reset:**
  - Simultaneous RX 0xA5 and TX 0x5A → both complete correctly.
  - Reset asserted mid-TX → uart_tx=1, write_ready_o=1, FIFO empty, flags cleared.
- **Parity (UART_LINK_PARITY_EN defined):**
  - 0x07 with parity bit 0 → error_parity_o=1, byte dropped.
  - TX 0x07 emits parity bit 1.
